// File: rtl/seg7_scan_ctrl_if.sv
// Message handshake bundle for the 7-segment scan controller.
// The producer offers a 16-bit message; the controller accepts it when ready.
interface seg7_scan_ctrl_if;
    logic [15:0] msg;
    logic        msg_valid;
    logic        msg_ready;

    modport master (
        output msg,
        output msg_valid,
        input  msg_ready
    );

    modport slave (
        input  msg,
        input  msg_valid,
        output msg_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller.
// Blanks each slot before enabling its anode; swaps messages only at frame ends.
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus,
    output logic [3:0]        char,
    output logic [3:0]        an,
    output logic              frame_done
);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;

    logic slot_last;
    logic boundary;

    // Slot/digit sequencing plus pending-buffer capture and frame-end apply
    always_comb begin
        slot_last = (cnt_q == CNT_LAST);
        boundary  = slot_last && (dig_q == 2'd0);
        cnt_d     = slot_last ? '0 : cnt_q + CW'(1);
        dig_d     = slot_last ? dig_q - 2'd1 : dig_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        if (boundary && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end else if (bus.msg_valid && !pend_v_q) begin
            pend_d   = bus.msg;
            pend_v_d = 1'b1;
        end
    end

    // State registers; reset restarts the frame at digit 3 with a blank message
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            dig_q    <= 2'd3;
            disp_q   <= 16'h0000;
            pend_q   <= 16'h0000;
            pend_v_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        char = 4'h0;
        an   = 4'b1111;
        unique case (dig_q)
            2'd3: char = disp_q[15:12];
            2'd2: char = disp_q[11:8];
            2'd1: char = disp_q[7:4];
            2'd0: char = disp_q[3:0];
            default: char = 4'h0;
        endcase
        if (cnt_q >= CNT_BLNK) begin
            an[dig_q] = 1'b0;
        end
        frame_done    = boundary;
        bus.msg_ready = !pend_v_q;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller for a 4-digit common-anode 7-segment display. It sequences the single shared `LEDdecoder` across four digits. Each scan slot presents one 4-bit character to the decoder, then enables the matching anode after a blanking interval to suppress ghosting. A new 16-bit message is accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes two messages.

## Interface
- `DIGIT_CYCLES`, default 16: clock cycles per digit slot. Must satisfy `DIGIT_CYCLES > BLANK_CYCLES`.
- `BLANK_CYCLES`, default 2: cycles at the start of each slot with all anodes off. Must be ≥ 1.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `msg` input, 16 bits: four characters. `msg[15:12]` is digit 3 (leftmost); `msg[3:0]` is digit 0.
- `msg_valid` input, 1 bit: `msg` is offered this cycle.
- `msg_ready` output, 1 bit: the pending buffer is empty and a message can be accepted.
- `char` output, 4 bits: character to the `LEDdecoder` input.
- `an` output, 4 bits: anode enables, active-low. `an[i]` drives digit i.
- `frame_done` output, 1 bit: one-cycle pulse on the last cycle of each frame.

## Operation
- **State:**
  - `cnt`: slot cycle counter, 0..DIGIT_CYCLES-1.
  - `dig`: current digit, 2 bits.
  - `disp`: displayed message, 16 bits.
  - `pend`: pending message, 16 bits.
  - `pend_v`: pending-valid flag, 1 bit.
- **Scan order:** `dig` counts 3 → 2 → 1 → 0 → 3, wrapping. `dig` decrements when `cnt` wraps from DIGIT_CYCLES-1 to 0.
- **Slot phases:**
  - BLANK (`cnt < BLANK_CYCLES`): `an = 4'b1111`; `char` = `disp` nibble for `dig`. The character is presented early so the decoder settles before the anode enables.
  - SHOW (`cnt ≥ BLANK_CYCLES`): `an` is all ones except `an[dig] = 0`; `char` = `disp` nibble for `dig`.
- **Frame:** four slots, `4*DIGIT_CYCLES` cycles, starting at `dig = 3`, `cnt = 0`.
  - The boundary cycle is `dig = 0`, `cnt = DIGIT_CYCLES-1`.
  - `frame_done = 1` in that cycle only.
- **Handshake:**
  - `msg_ready = !pend_v`.
  - A transfer occurs when `msg_valid && msg_ready` at a clock edge: `pend <= msg`, `pend_v <= 1`.
  - `msg` is ignored while `msg_ready = 0`.
- **Apply:** at the clock edge ending a boundary cycle, if `pend_v` was 1:
  - `disp <= pend` and `pend_v <= 0`.
  - The new message is shown from the first cycle of the next frame.
  - `msg_ready` returns to 1 in that same first cycle.
- **Simultaneous events:**
  - If `msg_valid` is high in a boundary cycle with `pend_v = 0`, the message is captured into `pend`. It is applied at the following boundary, not the current one.
  - If `pend_v = 1` in a boundary cycle, the old pending message is applied, and `msg_valid` in that cycle is not accepted because `msg_ready = 0`.
- **Reset** (asynchronous, any time, including mid-frame):
  - `cnt = 0`, `dig = 3`, `disp = 16'h0000`, `pend_v = 0`, `pend = 0`.
  - Any pending or partially displayed message is discarded.
- **Output path:** all outputs are driven purely from registered state. There is no combinational path from `msg` or `msg_valid` to any output.

## Timing
- **Outputs while `reset` is high:** `an = 4'b1111`, `char = 4'h0`, `msg_ready = 1`, `frame_done = 0`.
- **First cycle after reset release:** slot for digit 3, `cnt = 0`, BLANK phase.
- **Slot timing:** each slot is BLANK_CYCLES cycles of all-off followed by DIGIT_CYCLES-BLANK_CYCLES cycles of one-hot low anode.
  - Two anodes are never low in the same cycle.
  - The anode is never low during a slot's first cycle.
- **Message latency:** from acceptance to the first display cycle of the new message is at most `2*4*DIGIT_CYCLES` cycles, and at least 1 cycle.
- **Throughput:** at most one message is accepted per frame.

## Test plan
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2, with cycle 0 = first cycle after reset release.
- **Reset state:** hold `reset` high for 3 cycles → `an = 1111`, `char = 0`, `msg_ready = 1`, `frame_done = 0`. After release, cycles 0–1 `an = 1111`, cycles 2–7 `an = 0111`, `char = 0`.
- **Load and scan:** `msg = 16'h1234` with `msg_valid` at cycle 0 → `msg_ready = 0` from cycle 1 and `frame_done` at cycle 31. Then:
  - Cycles 32–33: `an = 1111`, `char = 1`.
  - Cycles 34–39: `an = 0111`, `char = 1`.
  - Cycles 42–47: `an = 1011`, `char = 2`.
  - Cycles 50–55: `an = 1101`, `char = 3`.
  - Cycles 58–63: `an = 1110`, `char = 4`.
  - `msg_ready = 1` at cycle 32.
- **Back-pressure:** offer `16'hABCD` at cycle 5 while `16'h1234` is pending → not accepted. Frame 2 shows 1,2,3,4 only.
- **Boundary collision:** `pend_v = 0`, `msg = 16'h5678` with `msg_valid` held only at boundary cycle 31 → accepted. Frame 2 still shows the old `disp`; frame 3 (from cycle 64) shows 5,6,7,8.
- **Reset mid-frame:** assert `reset` at cycle 44 with `16'h1234` displayed and `16'h9999` pending → `an = 1111` immediately. After release, digit 3 scans `char = 0`, `msg_ready = 1`, and `9` never appears.
- **Anode exclusivity:** run 10 frames with random messages → every cycle `an` is in {1111, 0111, 1011, 1101, 1110}. Each slot's first 2 cycles are 1111, and `frame_done` is high exactly once per 32 cycles.
